calendar_set_ctrl: RTL and testbench
====================================

# calendar_set_ctrl

Setting-mode sequencer for the calendar's field-increment demultiplexer. Turns three raw push-buttons (set, next, up) into a clean `on_off` enable, a 2-bit field select `mode` and a single-cycle `key` increment pulse. It also provides auto-repeat while up is held, an inactivity timeout and a blink strobe for the display. Its outputs drive the demux that routes `key` to the field counters.

## Interface
Parameters:
- `DEBOUNCE`, 16'd50000: consecutive stable cycles needed to accept a button level change (≥1).
- `HOLD_CYCLES`, 32'd25000000: cycles up must be held after its press pulse before the first repeat pulse.
- `REPEAT_CYCLES`, 32'd5000000: period between repeat pulses after the first.
- `TIMEOUT_CYCLES`, 32'd500000000: inactivity cycles before setting mode exits (≥2).
- `BLINK_CYCLES`, 32'd12500000: half-period of `blink`.

Ports:
- `clk` in 1: system clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous assert, active low.
- `btn_set` in 1: raw, asynchronous, active-high; enter/exit setting.
- `btn_next` in 1: raw, active-high; advance selected field.
- `btn_up` in 1: raw, active-high; increment selected field.
- `on_off` out 1: 1 while in setting mode.
- `mode` out 2: selected field, 00/01/10; 00 when not setting.
- `key` out 1: one-cycle increment pulse, never high when `on_off`=0.
- `blink` out 1: display blink strobe; 0 when not setting.

## Operation
- Input conditioning, per button:
  - 2-flop synchronizer.
  - Debounced level `db` flips after the synchronized value differs from `db` for `DEBOUNCE` consecutive cycles. Any agreeing cycle clears the counter.
  - Press event = `db` rising edge. Release events are ignored.
- FSM states and outputs:
  - IDLE: `on_off`=0, `mode`=00.
  - F0: `on_off`=1, `mode`=00.
  - F1: `on_off`=1, `mode`=01.
  - F2: `on_off`=1, `mode`=10.
- Transitions:
  - IDLE + set press → F0.
  - Fx + set press → IDLE.
  - F0 → F1 → F2 → F0 on next press (wraps).
  - Fx + timeout → IDLE.
  - IDLE ignores next and up.
- Event priority within one cycle: set > next > up. The lower-priority event is dropped entirely, not deferred.
- Key and auto-repeat:
  - In Fx, an up press produces one `key` pulse.
  - While up `db` stays high and the state is unchanged, a repeat counter runs. First repeat pulse comes `HOLD_CYCLES` cycles after the press pulse; subsequent pulses every `REPEAT_CYCLES`.
  - Release, any state change, or a suppressed press cancels repeat. Repeat resumes only after a fresh press.
- Timeout:
  - Counter clears on entering F0 and on every accepted event (set, next, up press, repeat pulse).
  - It increments each cycle in Fx. Reaching `TIMEOUT_CYCLES`-1 forces IDLE on the next edge.
  - The counter is held at 0 in IDLE.
- Blink:
  - Counter runs only in Fx; `blink` toggles every `BLINK_CYCLES`.
  - On entry to F0 and on each next press, `blink` is forced to 1 and its counter is cleared.
  - In IDLE, `blink`=0.
- Width rules: all counters are saturating-free, sized to their parameter, and compared for equality.

## Timing
- Reset (async, `rst_n`=0): state IDLE; `on_off`=0, `mode`=00, `key`=0, `blink`=0. Synchronizers and `db` are 0; all counters are 0.
- Reset mid-press or mid-repeat aborts with no pulse. After release of reset, a button already held must still pass the full debounce (`db` starts 0), so it yields one press.
- Latency from the first clock edge sampling a new stable raw level:
  - `db` flips at edge 2+`DEBOUNCE`.
  - The resulting registered outputs (`key` pulse, `mode`/`on_off` change) appear at edge 3+`DEBOUNCE` and are valid for the following cycle.
- `key` is high for exactly one cycle per press or repeat, and is never high in the cycle `on_off` falls.
- All outputs are registered; there are no combinational paths from inputs.

## Test plan
All scenarios use `DEBOUNCE`=4, `HOLD_CYCLES`=16, `REPEAT_CYCLES`=4, `TIMEOUT_CYCLES`=64, `BLINK_CYCLES`=8.
- Reset then set press held 10 cycles → `on_off`=1 and `mode`=00 at edge 7; `key` stays 0. A 3-cycle glitch on set → no change.
- In F0: three next presses → `mode` 01, 10, 00 in turn. An up press in F1 → one `key` pulse at press edge+7, `mode`=01.
- Up held 40 cycles in F2 → pulses at t, t+16, t+20, t+24, t+28, t+32, t+36 (7 total); none after release.
- No input for 64 cycles after entering F0 → `on_off`=0, `mode`=00 at cycle 64. A press at cycle 60 instead keeps F0, and IDLE comes 64 cycles after that press.
- Set and up debounced rising in the same cycle while in F1 → IDLE, no `key` pulse. Next and up together in F0 → F1, no pulse.
- `rst_n` low during auto-repeat → all outputs 0 immediately. Up still held at `rst_n` rise → no `key` while in IDLE.

Source files
------------

// File: rtl/calendar_set_ctrl.sv
// Setting-mode sequencer: conditions the set/next/up buttons, walks the
// field-select FSM, and generates the increment key, auto-repeat, inactivity
// timeout and display blink strobe.
module calendar_set_ctrl #(
  parameter logic [15:0] DEBOUNCE       = 16'd50000,
  parameter logic [31:0] HOLD_CYCLES    = 32'd25000000,
  parameter logic [31:0] REPEAT_CYCLES  = 32'd5000000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500000000,
  parameter logic [31:0] BLINK_CYCLES   = 32'd12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_set,
  input  logic       btn_next,
  input  logic       btn_up,
  output logic       on_off,
  output logic [1:0] mode,
  output logic       key,
  output logic       blink
);

  localparam int BtnSet  = 0;
  localparam int BtnNext = 1;
  localparam int BtnUp   = 2;

  typedef enum logic [1:0] {StIdle, StF0, StF1, StF2} state_e;

  // Button conditioning
  logic [2:0]  btn_raw;
  logic [2:0]  sync1_q, sync2_q;
  logic [2:0]  db_q, db_dly_q;
  logic [15:0] db_cnt_q [3];
  logic [2:0]  press;

  assign btn_raw = {btn_up, btn_next, btn_set};
  // Only rising edges of the debounced level are events
  assign press   = db_q & ~db_dly_q;

  // Synchronise, then accept a level change after DEBOUNCE disagreeing cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      db_dly_q <= db_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DEBOUNCE - 16'd1) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  // Sequencer state
  state_e      state_q, state_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        rep_act_q, rep_act_d;
  logic        rep_first_q, rep_first_d;
  logic [31:0] rep_cnt_q, rep_cnt_d;
  logic [31:0] blink_cnt_q, blink_cnt_d;
  logic        blink_q, blink_d;
  logic        key_q, key_d;
  logic        on_off_q;
  logic [1:0]  mode_q, mode_d;
  logic        restart_blink;
  logic        tmo_expired;
  logic [31:0] rep_lim;
  logic        rep_fire;

  assign tmo_expired = (tmo_cnt_q == TIMEOUT_CYCLES - 32'd1);
  // First repeat waits the hold time, later ones use the repeat period
  assign rep_lim     = rep_first_q ? HOLD_CYCLES : REPEAT_CYCLES;
  assign rep_fire    = rep_act_q & db_q[BtnUp] & (rep_cnt_q == rep_lim - 32'd1);

  // Next state, key pulse, timeout and repeat bookkeeping; set > next > up
  always_comb begin
    state_d       = state_q;
    key_d         = 1'b0;
    tmo_cnt_d     = '0;
    rep_act_d     = 1'b0;
    rep_first_d   = rep_first_q;
    rep_cnt_d     = '0;
    restart_blink = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (press[BtnSet]) begin
          state_d       = StF0;
          restart_blink = 1'b1;
        end
      end
      StF0, StF1, StF2: begin
        if (tmo_expired || press[BtnSet]) begin
          state_d = StIdle;
        end else if (press[BtnNext]) begin
          restart_blink = 1'b1;
          unique case (state_q)
            StF0:    state_d = StF1;
            StF1:    state_d = StF2;
            default: state_d = StF0;
          endcase
        end else if (press[BtnUp]) begin
          key_d       = 1'b1;
          rep_act_d   = 1'b1;
          rep_first_d = 1'b1;
        end else if (rep_fire) begin
          key_d       = 1'b1;
          rep_act_d   = 1'b1;
          rep_first_d = 1'b0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 32'd1;
          rep_act_d = rep_act_q & db_q[BtnUp];
          rep_cnt_d = rep_act_d ? rep_cnt_q + 32'd1 : 32'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Blink strobe runs only while setting; restarts high on entry and field change
  always_comb begin
    blink_d     = 1'b0;
    blink_cnt_d = '0;
    if (state_d != StIdle) begin
      if (restart_blink) begin
        blink_d = 1'b1;
      end else if (blink_cnt_q == BLINK_CYCLES - 32'd1) begin
        blink_d = ~blink_q;
      end else begin
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q + 32'd1;
      end
    end
  end

  // Field select decode of the next state, registered below
  always_comb begin
    mode_d = 2'b00;
    unique case (state_d)
      StF1:    mode_d = 2'b01;
      StF2:    mode_d = 2'b10;
      default: mode_d = 2'b00;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tmo_cnt_q   <= '0;
      rep_act_q   <= 1'b0;
      rep_first_q <= 1'b0;
      rep_cnt_q   <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      key_q       <= 1'b0;
      on_off_q    <= 1'b0;
      mode_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      rep_act_q   <= rep_act_d;
      rep_first_q <= rep_first_d;
      rep_cnt_q   <= rep_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      key_q       <= key_d;
      on_off_q    <= (state_d != StIdle);
      mode_q      <= mode_d;
    end
  end

  assign on_off = on_off_q;
  assign mode   = mode_q;
  assign key    = key_q;
  assign blink  = blink_q;

endmodule

// File: tb/tb_calendar_set_ctrl.sv
// Bench for calendar_set_ctrl: directed scenarios with literal expectations,
// then random button activity, all checked each cycle against a behavioural model.
module tb_calendar_set_ctrl;

  localparam int D = 4;
  localparam int H = 16;
  localparam int R = 4;
  localparam int T = 64;
  localparam int B = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_set = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_up = 1'b0;
  logic       on_off;
  logic [1:0] mode;
  logic       key;
  logic       blink;

  calendar_set_ctrl #(
    .DEBOUNCE      (16'd4),
    .HOLD_CYCLES   (32'd16),
    .REPEAT_CYCLES (32'd4),
    .TIMEOUT_CYCLES(32'd64),
    .BLINK_CYCLES  (32'd8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_set (btn_set),
    .btn_next(btn_next),
    .btn_up  (btn_up),
    .on_off  (on_off),
    .mode    (mode),
    .key     (key),
    .blink   (blink)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int key_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (key) key_cnt <= key_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Bit order in vectors: [0]=set, [1]=next, [2]=up
  logic [2:0] hist[$];  // hist[0] = raw sample taken at the previous edge
  logic [2:0] m_db;
  logic [2:0] m_pend;   // press events that act on the next edge
  int         m_st;     // -1 idle, else selected field
  int         m_last;   // edge of last accepted activity
  int         m_bstart; // edge blink last restarted
  int         m_rep_p;  // edge of the up press that armed repeat
  bit         m_rep;
  int         n_edge;
  logic       m_on, m_key, m_blink;
  logic [1:0] m_mode;

  task automatic model_reset();
    hist.delete();
    m_db = '0; m_pend = '0; m_st = -1; m_rep = 1'b0;
    m_on = 1'b0; m_key = 1'b0; m_blink = 1'b0; m_mode = 2'b00;
  endtask

  task automatic model_step();
    logic [2:0] raw;
    logic [2:0] newdb;
    bit sp, np, up, updb, fire, all_diff;
    int k;
    logic s;
    raw = {btn_up, btn_next, btn_set};
    n_edge++;
    sp = m_pend[0]; np = m_pend[1]; up = m_pend[2]; updb = m_db[2];
    m_key = 1'b0;
    if (m_st < 0) begin
      if (sp) begin
        m_st = 0; m_last = n_edge; m_bstart = n_edge;
      end
    end else begin
      k = n_edge - m_rep_p;
      fire = m_rep && updb && (k == H || (k > H && ((k - H) % R) == 0));
      if ((n_edge - m_last) == T || sp) begin
        m_st = -1; m_rep = 1'b0;
      end else if (np) begin
        m_st = (m_st + 1) % 3; m_last = n_edge; m_bstart = n_edge; m_rep = 1'b0;
      end else if (up) begin
        m_key = 1'b1; m_last = n_edge; m_rep = 1'b1; m_rep_p = n_edge;
      end else if (fire) begin
        m_key = 1'b1; m_last = n_edge;
      end else if (!updb) begin
        m_rep = 1'b0;
      end
    end
    // Level flips once the last D synchronised samples all disagree with it
    for (int b = 0; b < 3; b++) begin
      all_diff = 1'b1;
      for (int j = 1; j <= D; j++) begin
        s = (j < hist.size()) ? hist[j][b] : 1'b0;
        if (s == m_db[b]) all_diff = 1'b0;
      end
      newdb[b] = all_diff ? ~m_db[b] : m_db[b];
    end
    m_pend = newdb & ~m_db;
    m_db   = newdb;
    hist.push_front(raw);
    if (hist.size() > D + 2) void'(hist.pop_back());
    m_on    = (m_st >= 0);
    m_mode  = (m_st < 0) ? 2'b00 : 2'(m_st);
    m_blink = (m_st < 0) ? 1'b0 : ((((n_edge - m_bstart) / B) % 2) == 0);
  endtask

  initial begin
    n_edge = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("on_off", int'(on_off), int'(m_on));
    chk("mode", int'(mode), int'(m_mode));
    chk("key", int'(key), int'(m_key));
    chk("blink", int'(blink), int'(m_blink));
    chk("key_gated", int'(key & ~on_off), 0);
  end

  // ---------------- stimulus ----------------
  task automatic go(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic lit(input string name, input int dut_v, input int mdl_v, input int exp);
    chk({name, "_dut"}, dut_v, exp);
    chk({name, "_model"}, mdl_v, exp);
  endtask

  task automatic drive(input logic [2:0] m);
    {btn_up, btn_next, btn_set} = m;
  endtask

  // Hold buttons for 6 sampled edges from the current negedge; returns base edge
  task automatic tap(input logic [2:0] m, output int base);
    base = cyc;
    drive(m);
    go(base + 6);
    drive(3'b000);
  endtask

  initial begin
    int b, c, k0;
    logic [1:0] exp_mode;
    repeat (3) @(negedge clk);
    lit("rst_on_off", int'(on_off), int'(m_on), 0);
    lit("rst_mode", int'(mode), int'(m_mode), 0);
    lit("rst_key", int'(key), int'(m_key), 0);
    lit("rst_blink", int'(blink), int'(m_blink), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Set held 10 cycles enters F0 at the seventh edge
    b = cyc;
    drive(3'b001);
    go(b + 6);
    lit("set_pre", int'(on_off), int'(m_on), 0);
    go(b + 7);
    lit("set_on", int'(on_off), int'(m_on), 1);
    lit("set_mode", int'(mode), int'(m_mode), 0);
    lit("set_blink", int'(blink), int'(m_blink), 1);
    go(b + 10);
    drive(3'b000);
    // Three-cycle glitch is filtered out
    go(b + 20);
    drive(3'b001);
    go(b + 23);
    drive(3'b000);
    go(b + 32);
    lit("glitch_on", int'(on_off), int'(m_on), 1);

    // Next presses walk the fields and wrap
    for (int i = 0; i < 3; i++) begin
      tap(3'b010, b);
      go(b + 7);
      exp_mode = 2'((i + 1) % 3);
      lit("next_mode", int'(mode), int'(m_mode), int'(exp_mode));
      go(b + 18);
    end
    tap(3'b010, b);
    go(b + 18);

    // Single up press in F1
    tap(3'b100, b);
    go(b + 7);
    lit("up_key", int'(key), int'(m_key), 1);
    lit("up_mode", int'(mode), int'(m_mode), 1);
    go(b + 8);
    lit("up_key_end", int'(key), int'(m_key), 0);
    go(b + 18);
    tap(3'b010, b);
    go(b + 18);

    // Up held 40 cycles in F2: seven pulses
    b = cyc;
    k0 = key_cnt;
    drive(3'b100);
    go(b + 7);
    lit("rep_first", int'(key), int'(m_key), 1);
    go(b + 23);
    lit("rep_hold", int'(key), int'(m_key), 1);
    go(b + 40);
    drive(3'b000);
    go(b + 43);
    lit("rep_last", int'(key), int'(m_key), 1);
    go(b + 47);
    lit("rep_after", int'(key), int'(m_key), 0);
    go(b + 60);
    chk("rep_count", key_cnt - k0, 7);

    // Inactivity after the last pulse returns to idle
    go(b + 106);
    lit("tmo_pre", int'(on_off), int'(m_on), 1);
    go(b + 107);
    lit("tmo_on", int'(on_off), int'(m_on), 0);
    lit("tmo_blink", int'(blink), int'(m_blink), 0);

    // Up press at cycle 60 after entry restarts the timeout
    tap(3'b001, b);
    c = b + 7;
    go(c + 53);
    drive(3'b100);
    go(c + 59);
    drive(3'b000);
    go(c + 60);
    lit("late_key", int'(key), int'(m_key), 1);
    go(c + 64);
    lit("late_hold", int'(on_off), int'(m_on), 1);
    go(c + 123);
    lit("late_pre", int'(on_off), int'(m_on), 1);
    go(c + 124);
    lit("late_tmo", int'(on_off), int'(m_on), 0);
    go(c + 135);

    // Set and up together in F1: exit, no key
    tap(3'b001, b);
    go(b + 18);
    tap(3'b010, b);
    go(b + 18);
    k0 = key_cnt;
    tap(3'b101, b);
    go(b + 7);
    lit("setup_on", int'(on_off), int'(m_on), 0);
    go(b + 20);
    chk("setup_nokey", key_cnt - k0, 0);

    // Next and up together in F0: advance, no key
    tap(3'b001, b);
    go(b + 18);
    k0 = key_cnt;
    tap(3'b110, b);
    go(b + 7);
    lit("nextup_mode", int'(mode), int'(m_mode), 1);
    go(b + 20);
    chk("nextup_nokey", key_cnt - k0, 0);

    // Reset during auto-repeat, up still held afterwards
    b = cyc;
    drive(3'b100);
    go(b + 7);
    lit("rrep_key", int'(key), int'(m_key), 1);
    go(b + 25);
    #2 rst_n = 1'b0;
    @(negedge clk);
    lit("rrep_on", int'(on_off), int'(m_on), 0);
    lit("rrep_mode", int'(mode), int'(m_mode), 0);
    lit("rrep_blink", int'(blink), int'(m_blink), 0);
    rst_n = 1'b1;
    b = cyc;
    k0 = key_cnt;
    go(b + 30);
    chk("rrep_nokey", key_cnt - k0, 0);
    lit("rrep_idle", int'(on_off), int'(m_on), 0);
    drive(3'b000);
    go(b + 40);

    // Random button activity
    for (int it = 0; it < 250; it++) begin
      int r, hold, gap;
      logic [2:0] m;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        r = $urandom_range(0, 99);
        if (r < 15) m = 3'b001;
        else if (r < 40) m = 3'b010;
        else if (r < 85) m = 3'b100;
        else m = 3'($urandom_range(1, 7));
        hold = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 45);
        gap  = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 80) : $urandom_range(1, 12);
        drive(m);
        repeat (hold) @(negedge clk);
        drive(3'b000);
        repeat (gap) @(negedge clk);
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
